// File: rtl/arith_pkg.sv
// arith_pkg
// Shared definitions for the sequential arithmetic blocks.
// Contents:
//   op_t    : 2-bit operation codes (ADD, SUB, MUL, DIV)
//   state_t : control FSM encodings (IDLE, RUN, DONE)
//   FLAG_*  : bit positions of the cout/ovr/dz flags in a packed flag vector
package arith_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

  localparam int FLAG_COUT = 0;
  localparam int FLAG_OVR  = 1;
  localparam int FLAG_DZ   = 2;
  localparam int FLAG_W    = 3;

endpackage

// File: rtl/seq_arith_unit_if.sv
// seq_arith_unit_if
// Request/response bundle of the sequential arithmetic unit.
// Signals:
//   start, op[1:0], x[N-1:0], y[N-1:0]      : request side (driven by master)
//   busy, done, result[N-1:0], result_hi[N-1:0],
//   cout, ovr, dz                           : response side (driven by slave)
// Modports: master (requester), slave (arithmetic unit).
interface seq_arith_unit_if #(
  parameter int N = 8
) ();

  logic         start;
  logic [1:0]   op;
  logic [N-1:0] x;
  logic [N-1:0] y;
  logic         busy;
  logic         done;
  logic [N-1:0] result;
  logic [N-1:0] result_hi;
  logic         cout;
  logic         ovr;
  logic         dz;

  modport master (
    output start, op, x, y,
    input  busy, done, result, result_hi, cout, ovr, dz
  );

  modport slave (
    input  start, op, x, y,
    output busy, done, result, result_hi, cout, ovr, dz
  );

endinterface

// File: rtl/nbit_adder_ci.sv
// nbit_adder_ci
// N-bit ripple-carry adder with carry-in and carry-out.
// Ports:
//   a[N-1:0], b[N-1:0] : addends
//   ci                 : carry in
//   s[N-1:0]           : sum
//   co                 : carry out of the MSB
module nbit_adder_ci #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         ci,
  output logic [N-1:0] s,
  output logic         co
);

  logic carry;

  // One full adder per bit; the carry ripples from bit 0 upward.
  always_comb begin
    s     = '0;
    carry = ci;
    for (int i = 0; i < N; i++) begin
      s[i]  = a[i] ^ b[i] ^ carry;
      carry = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    co = carry;
  end

endmodule

// File: rtl/seq_arith_unit.sv
// seq_arith_unit
// Multi-cycle arithmetic unit: add, subtract, unsigned shift-add multiply and
// unsigned restoring divide, all through one shared N-bit adder.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset, aborts any operation in flight
//   bus  : seq_arith_unit_if.slave
//          start/op/x/y sampled when start is accepted (busy=0)
//          busy high while running, done pulses one cycle with results valid
//          result/result_hi/cout/ovr/dz hold until the next operation completes
module seq_arith_unit
  import arith_pkg::*;
#(
  parameter int N = 8
) (
  input logic            clk,
  input logic            rst,
  seq_arith_unit_if.slave bus
);

  localparam int CW = $clog2(N + 1);

  state_t            state_q, state_d;
  op_t               op_q;
  logic [2*N-1:0]    acc_q, acc_d;
  logic [N-1:0]      opnd_q;
  logic [CW-1:0]     cnt_q;

  logic [N-1:0]      res_q, res_d;
  logic [N-1:0]      res_hi_q, res_hi_d;
  logic [FLAG_W-1:0] flags_q, flags_d;

  logic [N-1:0]      add_a, add_b, add_s;
  logic              add_ci, add_co;
  logic [N-1:0]      shifted_hi;
  logic              div_ge;
  logic              accept, last, div_zero;

  // A request is taken whenever no iteration is running, which also covers
  // the DONE cycle so back-to-back operations lose no cycle.
  assign accept   = bus.start && (state_q != S_RUN);
  assign div_zero = (op_q == OP_DIV) && (opnd_q == '0);
  assign last     = (state_q == S_RUN) &&
                    ((op_q == OP_ADD) || (op_q == OP_SUB) || div_zero ||
                     (cnt_q == CW'(N - 1)));

  // For divide the partial remainder is shifted left by one before the trial
  // subtract; the bit shifted out of the top is folded into the compare.
  assign shifted_hi = acc_q[2*N-2:N-1];

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_RUN;
      S_RUN:   if (last)   state_d = S_DONE;
      S_DONE:  state_d = accept ? S_RUN : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Adder operand selection. The accumulator's low half holds x for ADD/SUB,
  // the multiplier for MUL and the dividend/quotient for DIV.
  always_comb begin
    add_a  = acc_q[N-1:0];
    add_b  = opnd_q;
    add_ci = 1'b0;
    case (op_q)
      OP_SUB: begin
        add_b  = ~opnd_q;
        add_ci = 1'b1;
      end
      OP_MUL: begin
        add_a = acc_q[2*N-1:N];
        add_b = acc_q[0] ? opnd_q : '0;
      end
      OP_DIV: begin
        add_a  = shifted_hi;
        add_b  = ~opnd_q;
        add_ci = 1'b1;
      end
      default: ;
    endcase
  end

  nbit_adder_ci #(.N(N)) u_adder (
    .a  (add_a),
    .b  (add_b),
    .ci (add_ci),
    .s  (add_s),
    .co (add_co)
  );

  // Next accumulator value and the result/flags that would be committed if
  // this is the final iteration.
  always_comb begin
    acc_d    = acc_q;
    div_ge   = acc_q[2*N-1] | add_co;
    res_d    = add_s;
    res_hi_d = '0;
    flags_d  = '0;
    case (op_q)
      OP_ADD, OP_SUB: begin
        flags_d[FLAG_COUT] = add_co;
        flags_d[FLAG_OVR]  = (add_a[N-1] == add_b[N-1]) && (add_s[N-1] != add_a[N-1]);
      end
      OP_MUL: begin
        acc_d              = {add_co, add_s, acc_q[N-1:1]};
        res_d              = acc_d[N-1:0];
        res_hi_d           = acc_d[2*N-1:N];
        flags_d[FLAG_COUT] = |acc_d[2*N-1:N];
      end
      OP_DIV: begin
        if (div_ge) acc_d = {add_s, acc_q[N-2:0], 1'b1};
        else        acc_d = {shifted_hi, acc_q[N-2:0], 1'b0};
        if (div_zero) begin
          res_d            = '1;
          res_hi_d         = acc_q[N-1:0];
          flags_d[FLAG_DZ] = 1'b1;
        end else begin
          res_d    = acc_d[N-1:0];
          res_hi_d = acc_d[2*N-1:N];
        end
      end
      default: ;
    endcase
  end

  // Working registers load on accept and step once per RUN cycle; the visible
  // outputs only change on the final iteration.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q     <= OP_ADD;
      acc_q    <= '0;
      opnd_q   <= '0;
      cnt_q    <= '0;
      res_q    <= '0;
      res_hi_q <= '0;
      flags_q  <= '0;
    end else if (accept) begin
      op_q   <= op_t'(bus.op);
      acc_q  <= {{N{1'b0}}, bus.x};
      opnd_q <= bus.y;
      cnt_q  <= '0;
    end else if (state_q == S_RUN) begin
      acc_q <= acc_d;
      cnt_q <= cnt_q + CW'(1);
      if (last) begin
        res_q    <= res_d;
        res_hi_q <= res_hi_d;
        flags_q  <= flags_d;
      end
    end
  end

  assign bus.busy      = (state_q == S_RUN);
  assign bus.done      = (state_q == S_DONE);
  assign bus.result    = res_q;
  assign bus.result_hi = res_hi_q;
  assign bus.cout      = flags_q[FLAG_COUT];
  assign bus.ovr       = flags_q[FLAG_OVR];
  assign bus.dz        = flags_q[FLAG_DZ];

endmodule
